alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
//  Execute stage wrapped around the 16-bit ALU (ports a, b, ci, nb, out).
//  - Accepts register-to-register and register-immediate ADD/SUB ops over a valid/ready handshake.
//  - Reads operands from an internal register file and drives the ALU.
//  - Registers the result and writes it back one cycle later; keeps Z/N flags.
// PARAMETERS
//  WIDTH   16  datapath width; must match the ALU width
//  NREGS   8   register count; r0 is hardwired to zero
//  AW      $clog2(NREGS)  register address width (derived, not overridable)
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      instruction present
//  in_ready   out  1      stage accepts instruction this cycle
//  in_op      in   2      00 ADD, 01 SUB, 10 ADDI, 11 SUBI
//  in_rd      in   AW     destination register
//  in_rs1     in   AW     source A
//  in_rs2     in   AW     source B (ignored for ADDI/SUBI)
//  in_imm     in   WIDTH  immediate B (ignored for ADD/SUB)
//  res_valid  out  1      writeback occurring this cycle
//  res_rd     out  AW     writeback register
//  res_data   out  WIDTH  writeback value
//  z_flag     out  1      last written result == 0
//  n_flag     out  1      last written result MSB
//  dbg_addr   in   AW     debug read address
//  dbg_data   out  WIDTH  combinational regfile read; r0 reads 0
// BEHAVIOUR
//  - Reset: all regs 0; res_valid/res_rd/res_data/z_flag/n_flag = 0. in_ready = 1 as soon as rst_n rises.
//  - Reset mid-operation: an in-flight result is discarded and never written back.
//  - Accept on in_valid && in_ready (cycle N).
//    - Operand A = R[rs1].
//    - Operand B = R[rs2] (ADD/SUB) or in_imm (ADDI/SUBI).
//  - ALU controls: ADD/ADDI -> ci=0, nb=0; SUB/SUBI -> ci=1, nb=1.
//  - Arithmetic is modulo 2^WIDTH with no overflow detection. Example: 7 + (-9) = 16'hFFFE.
//  - ALU out is captured at the end of N into res_* and res_valid=1 for cycle N+1.
//  - At the end of N+1: R[res_rd] <= res_data, z_flag/n_flag updated.
//  - Writes to r0 are dropped. res_valid still pulses, and flags still update from the computed value.
//  - Latency: accept -> res_valid is 1 cycle; accept -> regfile visible is 2 cycles. Throughput is 1 op/cycle with no hazard.
//  - No accept in N: res_valid = 0 in N+1; res_rd/res_data hold their previous values.
//  - Hazard: instruction in N+1 reads (rs1, or rs2 for reg ops) == res_rd with res_valid=1 and res_rd != 0. Handling depends on ALU_FWD_EN.
//  - Same-cycle read/write of the regfile does not bypass internally. Hazard logic alone covers this case.
//  - dbg_data reflects the regfile state, not the pending res_data.
// CONFIGURATION
//  ALU_FWD_EN defined:
//  - res_data is forwarded into operand A and/or B on a hazard.
//  - in_ready is held at 1.
//  ALU_FWD_EN undefined:
//  - in_ready = 0 for the hazard cycle, a one-bubble stall.
//  - The instruction is accepted the next cycle, after writeback. res_valid = 0 in the following cycle.
// STRUCTURE
//  - Package alu_exec_pkg:
//    - op_e enum (OP_ADD, OP_SUB, OP_ADDI, OP_SUBI)
//    - WIDTH_DEF=16, NREGS_DEF=8
//    - function is_imm(op_e), function is_sub(op_e)
//  - Sub-module exec_regfile:
//    - NREGS x WIDTH; 2 combinational read ports plus 1 debug read port
//    - 1 synchronous write port; r0 reads 0
//    - async active-low clear
//  - The ALU is instantiated unchanged; hazard/forward muxing lives in alu_exec_stage.
// TESTING
//  1. Reset mid-op: accept ADDI r1,r0,5, assert rst_n=0 before writeback. Expect res_valid=0, flags 0, dbg r1=0.
//  2. ADDI r1,r0,9; ADDI r2,r0,8; then (after 2 idle cycles) ADD r3,r1,r2.
//     Expect res_data=17, dbg r3=17, z=0, n=0.
//  3. ADDI r1,r0,7; ADDI r2,r0,16'hFFF7; (after 2 idle cycles) ADD r3,r1,r2.
//     Expect res_data=16'hFFFE, n_flag=1.
//  4. Back-to-back ADDI r1,r0,10 then SUBI r1,r1,4.
//     - With ALU_FWD_EN: second res_valid 1 cycle later, value 6, in_ready never low.
//     - Without ALU_FWD_EN: in_ready=0 for one cycle, value 6 one cycle later.
//  5. SUB r4,r1,r1 with r1=6: expect res_data=0, z_flag=1.
//     Then ADDI r0,r0,3: expect res_valid=1, z=0, dbg r0 still 0.
//  6. Stream of 8 independent ADDI (rd=1..7, imm=rd*3) with in_valid held high.
//     Expect res_valid high for 8 consecutive cycles and correct dbg readback.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared types and helpers for the ALU execute stage.
//   op_e      : 2-bit opcode (ADD, SUB, ADDI, SUBI)
//   is_imm()  : operand B comes from the immediate
//   is_sub()  : ALU runs in subtract mode (invert B, carry-in 1)
package alu_exec_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned NREGS_DEF = 8;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ADDI = 2'b10,
    OP_SUBI = 2'b11
  } op_e;

  function automatic logic is_imm(op_e op);
    return (op == OP_ADDI) || (op == OP_SUBI);
  endfunction

  function automatic logic is_sub(op_e op);
    return (op == OP_SUB) || (op == OP_SUBI);
  endfunction

endpackage

// File: rtl/alu.sv
// Plain WIDTH-bit adder/subtractor.
//   a, b : operands
//   ci   : carry in
//   nb   : invert b before the add (a - b when combined with ci = 1)
//   out  : a + (nb ? ~b : b) + ci, modulo 2^WIDTH
module alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             nb,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff = nb ? ~b : b;
  assign out   = a + b_eff + {{(WIDTH-1){1'b0}}, ci};

endmodule

// File: rtl/exec_regfile.sv
// NREGS x WIDTH register file for the execute stage.
//   clk_i, rst_ni            : clock, async active-low clear (all registers to 0)
//   we_i, waddr_i, wdata_i   : synchronous write port; writes to r0 are dropped
//   raddr_a_i / rdata_a_o    : combinational read port A
//   raddr_b_i / rdata_b_o    : combinational read port B
//   dbg_addr_i / dbg_data_o  : combinational debug read port
// No write-to-read bypass: a read in the write cycle returns the old value.
module exec_regfile import alu_exec_pkg::*; #(
  parameter  int unsigned WIDTH = WIDTH_DEF,
  parameter  int unsigned NREGS = NREGS_DEF,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_a_i,
  output logic [WIDTH-1:0] rdata_a_o,
  input  logic [AW-1:0]    raddr_b_i,
  output logic [WIDTH-1:0] rdata_b_o,
  input  logic [AW-1:0]    dbg_addr_i,
  output logic [WIDTH-1:0] dbg_data_o
);

  logic [WIDTH-1:0] regs_q [NREGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = (raddr_a_i  == '0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o  = (raddr_b_i  == '0) ? '0 : regs_q[raddr_b_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage around the ALU: ADD/SUB/ADDI/SUBI over a valid/ready handshake.
//   clk, rst_n                       : clock, async active-low reset
//   in_valid/in_ready                : instruction handshake
//   in_op, in_rd, in_rs1, in_rs2,
//   in_imm                           : instruction fields
//   res_valid, res_rd, res_data      : writeback (one cycle after accept)
//   z_flag, n_flag                   : zero / sign of the last written result
//   dbg_addr, dbg_data               : combinational regfile peek (r0 reads 0)
// Build option ALU_FWD_EN: forward res_data on a read-after-write hazard instead
// of stalling one cycle.
module alu_exec_stage import alu_exec_pkg::*; #(
  parameter  int unsigned WIDTH = WIDTH_DEF,
  parameter  int unsigned NREGS = NREGS_DEF,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [AW-1:0]    in_rd,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic [WIDTH-1:0] in_imm,
  output logic             res_valid,
  output logic [AW-1:0]    res_rd,
  output logic [WIDTH-1:0] res_data,
  output logic             z_flag,
  output logic             n_flag,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  op_e              op;
  logic             use_imm;
  logic             do_sub;
  logic             accept;
  logic             haz_a;
  logic             haz_b;
  logic [WIDTH-1:0] rf_a;
  logic [WIDTH-1:0] rf_b;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] alu_out;

  logic             res_valid_q, res_valid_d;
  logic [AW-1:0]    res_rd_q,    res_rd_d;
  logic [WIDTH-1:0] res_data_q,  res_data_d;
  logic             z_q,         z_d;
  logic             n_q,         n_d;

  assign op      = op_e'(in_op);
  assign use_imm = is_imm(op);
  assign do_sub  = is_sub(op);

  exec_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .we_i       (res_valid_q),
    .waddr_i    (res_rd_q),
    .wdata_i    (res_data_q),
    .raddr_a_i  (in_rs1),
    .rdata_a_o  (rf_a),
    .raddr_b_i  (in_rs2),
    .rdata_b_o  (rf_b),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  // The regfile has no internal bypass, so a source matching the pending
  // writeback (other than r0) would read a stale value this cycle.
  assign haz_a = res_valid_q && (res_rd_q != '0) && (in_rs1 == res_rd_q);
  assign haz_b = res_valid_q && (res_rd_q != '0) && !use_imm && (in_rs2 == res_rd_q);

`ifdef ALU_FWD_EN
  assign opa      = haz_a ? res_data_q : rf_a;
  assign opb      = use_imm ? in_imm : (haz_b ? res_data_q : rf_b);
  assign in_ready = 1'b1;
`else
  assign opa      = rf_a;
  assign opb      = use_imm ? in_imm : rf_b;
  // One bubble: next cycle the writeback has landed and res_valid is low.
  assign in_ready = !(in_valid && (haz_a || haz_b));
`endif

  assign accept = in_valid && in_ready;

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a   (opa),
    .b   (opb),
    .ci  (do_sub),
    .nb  (do_sub),
    .out (alu_out)
  );

  always_comb begin
    res_valid_d = accept;
    res_rd_d    = res_rd_q;
    res_data_d  = res_data_q;
    z_d         = z_q;
    n_d         = n_q;
    if (accept) begin
      res_rd_d   = in_rd;
      res_data_d = alu_out;
    end
    // Flags follow the computed value even when the r0 write is dropped.
    if (res_valid_q) begin
      z_d = (res_data_q == '0);
      n_d = res_data_q[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_rd_q    <= '0;
      res_data_q  <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
    end else begin
      res_valid_q <= res_valid_d;
      res_rd_q    <= res_rd_d;
      res_data_q  <= res_data_d;
      z_q         <= z_d;
      n_q         <= n_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_rd    = res_rd_q;
  assign res_data  = res_data_q;
  assign z_flag    = z_q;
  assign n_flag    = n_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: reset, table of isolated ops, hazard pairs,
// and a full-rate stream.
module tb_alu_exec_stage;

  localparam logic [1:0] ADD  = 2'b00;
  localparam logic [1:0] SUB  = 2'b01;
  localparam logic [1:0] ADDI = 2'b10;
  localparam logic [1:0] SUBI = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [2:0]  in_rd, in_rs1, in_rs2;
  logic [15:0] in_imm;
  logic        res_valid;
  logic [2:0]  res_rd;
  logic [15:0] res_data;
  logic        z_flag, n_flag;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_exec_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .res_valid (res_valid),
    .res_rd    (res_rd),
    .res_data  (res_data),
    .z_flag    (z_flag),
    .n_flag    (n_flag),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] imm;
    logic [15:0] exp;
    logic        z;
    logic        n;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [15:0] imm);
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
  endtask

  task automatic peek(input string name, input logic [2:0] addr, input logic [15:0] exp);
    dbg_addr = addr;
    #1;
    chk(name, {16'h0, dbg_data}, {16'h0, exp});
  endtask

  // Second op depends on the first one's destination.
  task automatic back_to_back(input string name,
                              input logic [1:0] op1, input logic [2:0] rd1,
                              input logic [2:0] rs1a, input logic [2:0] rs2a,
                              input logic [15:0] imm1, input logic [15:0] exp1,
                              input logic [1:0] op2, input logic [2:0] rd2,
                              input logic [2:0] rs1b, input logic [2:0] rs2b,
                              input logic [15:0] imm2, input logic [15:0] exp2);
    drive(op1, rd1, rs1a, rs2a, imm1);
    #1;
    chk({name, " ready1"}, {31'h0, in_ready}, 32'h1);
    tick();
    chk({name, " valid1"}, {31'h0, res_valid}, 32'h1);
    chk({name, " data1"}, {16'h0, res_data}, {16'h0, exp1});
    drive(op2, rd2, rs1b, rs2b, imm2);
    #1;
`ifdef ALU_FWD_EN
    chk({name, " ready2 fwd"}, {31'h0, in_ready}, 32'h1);
    tick();
`else
    chk({name, " ready2 stall"}, {31'h0, in_ready}, 32'h0);
    tick();
    chk({name, " bubble"}, {31'h0, res_valid}, 32'h0);
    chk({name, " ready after stall"}, {31'h0, in_ready}, 32'h1);
    tick();
`endif
    in_valid = 1'b0;
    chk({name, " valid2"}, {31'h0, res_valid}, 32'h1);
    chk({name, " data2"}, {16'h0, res_data}, {16'h0, exp2});
    tick();
    peek({name, " dbg"}, rd2, exp2);
    chk({name, " z"}, {31'h0, z_flag}, {31'h0, exp2 == 16'h0});
    chk({name, " n"}, {31'h0, n_flag}, {31'h0, exp2[15]});
    tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_op    = ADD;
    in_rd    = '0;
    in_rs1   = '0;
    in_rs2   = '0;
    in_imm   = '0;
    dbg_addr = '0;

    //           op    rd    rs1   rs2   imm       exp       z     n
    vecs[0]  = '{ADDI, 3'd1, 3'd0, 3'd0, 16'd9,    16'd9,    1'b0, 1'b0};
    vecs[1]  = '{ADDI, 3'd2, 3'd0, 3'd0, 16'd8,    16'd8,    1'b0, 1'b0};
    vecs[2]  = '{ADD,  3'd3, 3'd1, 3'd2, 16'hDEAD, 16'd17,   1'b0, 1'b0};
    vecs[3]  = '{ADDI, 3'd1, 3'd0, 3'd0, 16'd7,    16'd7,    1'b0, 1'b0};
    vecs[4]  = '{ADDI, 3'd2, 3'd0, 3'd0, 16'hFFF7, 16'hFFF7, 1'b0, 1'b1};
    vecs[5]  = '{ADD,  3'd3, 3'd1, 3'd2, 16'h0000, 16'hFFFE, 1'b0, 1'b1};
    vecs[6]  = '{ADDI, 3'd1, 3'd0, 3'd0, 16'd6,    16'd6,    1'b0, 1'b0};
    vecs[7]  = '{SUB,  3'd4, 3'd1, 3'd1, 16'h1234, 16'd0,    1'b1, 1'b0};
    vecs[8]  = '{ADDI, 3'd0, 3'd0, 3'd0, 16'd3,    16'd3,    1'b0, 1'b0};
    vecs[9]  = '{SUBI, 3'd5, 3'd0, 3'd7, 16'd1,    16'hFFFF, 1'b0, 1'b1};
    vecs[10] = '{SUB,  3'd6, 3'd2, 3'd1, 16'd0,    16'hFFF1, 1'b0, 1'b1};

    // Reset state.
    tick();
    tick();
    chk("reset res_valid", {31'h0, res_valid}, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("reset in_ready", {31'h0, in_ready}, 32'h1);
    chk("reset res_data", {16'h0, res_data}, 32'h0);
    chk("reset res_rd", {29'h0, res_rd}, 32'h0);
    chk("reset z", {31'h0, z_flag}, 32'h0);
    chk("reset n", {31'h0, n_flag}, 32'h0);
    tick();

    // Reset while a result is pending.
    drive(ADDI, 3'd1, 3'd0, 3'd0, 16'd5);
    tick();
    in_valid = 1'b0;
    chk("midrst valid before", {31'h0, res_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst res_valid", {31'h0, res_valid}, 32'h0);
    chk("midrst res_data", {16'h0, res_data}, 32'h0);
    chk("midrst z", {31'h0, z_flag}, 32'h0);
    chk("midrst n", {31'h0, n_flag}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst valid after", {31'h0, res_valid}, 32'h0);
    peek("midrst dbg r1", 3'd1, 16'd0);

    // Isolated ops, two idle cycles apart so no hazards arise.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      #1;
      chk($sformatf("vec%0d ready", i), {31'h0, in_ready}, 32'h1);
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d valid", i), {31'h0, res_valid}, 32'h1);
      chk($sformatf("vec%0d rd", i), {29'h0, res_rd}, {29'h0, vecs[i].rd});
      chk($sformatf("vec%0d data", i), {16'h0, res_data}, {16'h0, vecs[i].exp});
      tick();
      chk($sformatf("vec%0d valid drop", i), {31'h0, res_valid}, 32'h0);
      chk($sformatf("vec%0d data hold", i), {16'h0, res_data}, {16'h0, vecs[i].exp});
      chk($sformatf("vec%0d z", i), {31'h0, z_flag}, {31'h0, vecs[i].z});
      chk($sformatf("vec%0d n", i), {31'h0, n_flag}, {31'h0, vecs[i].n});
      peek($sformatf("vec%0d dbg", i), vecs[i].rd,
           (vecs[i].rd == 3'd0) ? 16'd0 : vecs[i].exp);
      tick();
    end

    // Hazard on rs1, then on rs2 of a register op.
    back_to_back("haz rs1", ADDI, 3'd1, 3'd0, 3'd0, 16'd10, 16'd10,
                            SUBI, 3'd1, 3'd1, 3'd0, 16'd4, 16'd6);
    back_to_back("haz rs2", ADDI, 3'd3, 3'd0, 3'd0, 16'd1, 16'd1,
                            ADD,  3'd4, 3'd1, 3'd3, 16'd0, 16'd7);

    // A pending write to r0 is not a hazard.
    drive(ADDI, 3'd0, 3'd0, 3'd0, 16'd5);
    tick();
    drive(ADDI, 3'd2, 3'd0, 3'd0, 16'd1);
    #1;
    chk("r0 no hazard ready", {31'h0, in_ready}, 32'h1);
    tick();
    in_valid = 1'b0;
    chk("r0 no hazard valid", {31'h0, res_valid}, 32'h1);
    chk("r0 no hazard data", {16'h0, res_data}, 32'h1);
    tick();
    tick();

    // Full-rate stream of independent ops.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] rd;
      rd = 3'((i % 7) + 1);
      drive(ADDI, rd, 3'd0, 3'd0, 16'(rd * 3));
      #1;
      chk($sformatf("stream%0d ready", i), {31'h0, in_ready}, 32'h1);
      tick();
      chk($sformatf("stream%0d valid", i), {31'h0, res_valid}, 32'h1);
      chk($sformatf("stream%0d data", i), {16'h0, res_data}, 32'(rd * 3));
    end
    in_valid = 1'b0;
    tick();
    chk("stream end valid", {31'h0, res_valid}, 32'h0);
    for (int r = 1; r < 8; r++) begin
      peek($sformatf("stream dbg r%0d", r), 3'(r), 16'(r * 3));
    end
    peek("dbg r0", 3'd0, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
